// File: rtl/mdu_if.sv
// Handshake and result bundle between the Execute stage and the MDU sequencer.
// E drives the op; the MDU returns busy and the architectural HI/LO.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, req,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, req,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: fixed-latency busy window, owns HI/LO,
// squashes ops flushed by req while they are still in E.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [0:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        pwr_q, pwr_d;

  logic [63:0] smul, umul;
  logic [31:0] a_mag, b_mag;
  logic [31:0] dvs_s, dvs_u;
  logic [31:0] sq, sr, sq_fix, sr_fix;
  logic [31:0] uq, ur;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;
  logic        b_zero;

  assign b_zero = (bus.b == 32'd0);

  // Low 64 bits of the sign-extended product are the signed product.
  assign smul = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign umul = {32'd0, bus.a} * {32'd0, bus.b};

  // Signed divide on magnitudes avoids the INT_MIN / -1 overflow trap.
  assign a_mag  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign b_mag  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
  assign dvs_s  = b_zero ? 32'd1 : b_mag;
  assign dvs_u  = b_zero ? 32'd1 : bus.b;
  assign sq     = a_mag / dvs_s;
  assign sr     = a_mag % dvs_s;
  assign sq_fix = (bus.a[31] ^ bus.b[31]) ? (~sq + 32'd1) : sq;
  assign sr_fix = bus.a[31] ? (~sr + 32'd1) : sr;
  assign uq     = bus.a / dvs_u;
  assign ur     = bus.a % dvs_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    unique case (1'b1)
      (bus.op == OP_MULT): begin
        res_hi = smul[63:32];
        res_lo = smul[31:0];
        res_wr = 1'b1;
      end
      (bus.op == OP_MULTU): begin
        res_hi = umul[63:32];
        res_lo = umul[31:0];
        res_wr = 1'b1;
      end
      (bus.op == OP_DIV): begin
        res_hi = sr_fix;
        res_lo = sq_fix;
        res_wr = !b_zero;
      end
      (bus.op == OP_DIVU): begin
        res_hi = ur;
        res_lo = uq;
        res_wr = !b_zero;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.req) begin
          unique case (1'b1)
            (bus.op <= OP_DIVU): begin
              state_d = S_BUSY;
              cnt_d   = bus.op[1] ? 16'(DIV_CYCLES)
                                  : 16'(MUL_CYCLES);
              phi_d   = res_hi;
              plo_d   = res_lo;
              pwr_d   = res_wr;
            end
            (bus.op == OP_MTHI): hi_d = bus.a;
            (bus.op == OP_MTLO): lo_d = bus.a;
            default: ;
          endcase
        end
      end
      default: begin
        // start while busy is ignored; the stall unit prevents it.
        if (cnt_q <= 16'd1) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  assign bus.busy = (state_q == S_BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl against an arithmetic HI/LO model.
// Directed cases first, then a randomized op stream.
module tb_mdu_ctrl;

  localparam int MUL = 5;
  localparam int DIV = 10;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_if bus();

  mdu_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(bus.start && bus.busy))
      else $error("start issued while busy");
  end

  function automatic int lat(input logic [2:0] op);
    if (op <= 3'd1) return MUL;
    if (op <= 3'd3) return DIV;
    return 0;
  endfunction

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin
        p = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd1: begin
        p = ua * ub;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = 32'(q);
        m_hi = 32'(r);
      end
      3'd3: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", name, got, exp);
    else
      n_pass++;
  endtask

  // Issues one op at a negedge, checks busy each cycle, then HI/LO.
  task automatic do_op(input string name,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int req_at);
    int n;
    n = lat(op);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.req   = (i == req_at);
      chk({name, " busy"}, 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.req   = 1'b0;
    model(op, a, b);
    chk({name, " busy_done"}, 32'(bus.busy), 32'd0);
    chk({name, " hi"}, bus.hi, m_hi);
    chk({name, " lo"}, bus.lo, m_lo);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst hi", bus.hi, 32'd0);
    chk("rst lo", bus.lo, 32'd0);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult;
    do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mult hi const", bus.hi, 32'hFFFF_FFFF);
    chk("mult lo const", bus.lo, 32'hFFFF_FFFA);
    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu hi const", bus.hi, 32'hFFFF_FFFE);
    chk("multu lo const", bus.lo, 32'h0000_0001);
  endtask

  task automatic test_div;
    do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div lo const", bus.lo, 32'hFFFF_FFFD);
    chk("div hi const", bus.hi, 32'hFFFF_FFFF);
    do_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div ovf lo const", bus.lo, 32'h8000_0000);
    chk("div ovf hi const", bus.hi, 32'h0000_0000);
  endtask

  task automatic test_div_zero;
    do_op("mthi", 3'd4, 32'h1234, 32'd0, 0);
    do_op("mtlo", 3'd5, 32'h5678, 32'd0, 0);
    do_op("divu0", 3'd3, 32'hDEAD_BEEF, 32'd0, 0);
    chk("divu0 hi const", bus.hi, 32'h1234);
    chk("divu0 lo const", bus.lo, 32'h5678);
  endtask

  task automatic test_req_same_cycle;
    @(negedge clk);
    bus.start = 1'b1;
    bus.req   = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    for (int i = 0; i < MUL + 2; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.req   = 1'b0;
      chk("req0 busy", 32'(bus.busy), 32'd0);
    end
    chk("req0 hi", bus.hi, m_hi);
    chk("req0 lo", bus.lo, m_lo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.req   = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'hCAFE_0000;
    @(negedge clk);
    bus.start = 1'b0;
    bus.req   = 1'b0;
    chk("req0 mthi hi", bus.hi, m_hi);
  endtask

  task automatic test_req_busy;
    do_op("req2", 3'd0, 32'd2, 32'd3, 2);
    chk("req2 lo const", bus.lo, 32'd6);
    chk("req2 hi const", bus.hi, 32'd0);
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rmid busy3", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("rmid busy", 32'(bus.busy), 32'd0);
    chk("rmid hi", bus.hi, 32'd0);
    chk("rmid lo", bus.lo, 32'd0);
    repeat (DIV + 2) @(negedge clk);
    chk("rmid late busy", 32'(bus.busy), 32'd0);
    chk("rmid late hi", bus.hi, 32'd0);
    chk("rmid late lo", bus.lo, 32'd0);
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel;
    for (int k = 0; k < 40; k++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = 32'hFFFF_FFFF;
      if (sel == 2) a = 32'h8000_0000;
      if (sel == 3) b = 32'($urandom_range(1, 9));
      do_op("rand", op, a, b, (sel == 4) ? 1 : 0);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.req   = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_req_same_cycle;
    test_reset;
    test_req_busy;
    test_reset_midop;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
